// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - gate op encoding, sweep FSM states and the golden gate model
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_BUF  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } sweep_state_t;

  function automatic logic gate_eval(input logic [2:0] op, input logic a, input logic b);
    case (op)
      OP_AND:  gate_eval = a & b;
      OP_OR:   gate_eval = a | b;
      OP_XOR:  gate_eval = a ^ b;
      OP_NAND: gate_eval = ~(a & b);
      OP_NOR:  gate_eval = ~(a | b);
      OP_XNOR: gate_eval = ~(a ^ b);
      OP_NOT:  gate_eval = ~a;
      default: gate_eval = a;
    endcase
  endfunction

endpackage

// File: rtl/gate_sweep_idx.sv
// rtl/gate_sweep_idx.sv - op/vector index with priority search for the next enabled op
module gate_sweep_idx
  import gate_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] mask_in,
  input  logic       advance,
  output logic [2:0] cur_op,
  output logic [1:0] cur_vec,
  output logic       last,
  output logic       mask_zero
);

  logic [7:0] mask;
  logic [2:0] first_op;
  logic [2:0] next_op;
  logic       next_found;

  // Descending scans so the lowest qualifying index is the one left standing.
  always_comb begin
    first_op   = OP_AND;
    next_op    = cur_op;
    next_found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_in[i]) first_op = 3'(i);
      if (mask[i] && (3'(i) > cur_op)) begin
        next_op    = 3'(i);
        next_found = 1'b1;
      end
    end
  end

  assign mask_zero = (mask_in == 8'h00);
  assign last      = (cur_vec == 2'd3) && !next_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask    <= 8'h00;
      cur_op  <= OP_AND;
      cur_vec <= 2'd0;
    end else if (load) begin
      mask    <= mask_in;
      cur_op  <= first_op;
      cur_vec <= 2'd0;
    end else if (advance) begin
      if (cur_vec == 2'd3) begin
        cur_vec <= 2'd0;
        cur_op  <= next_op;
      end else begin
        cur_vec <= cur_vec + 2'd1;
      end
    end
  end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - gate unit sweep sequencer; GATE_SWEEP_TRACE_EN adds first-mismatch capture
module gate_sweep_ctrl
  import gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] op_en,
  input  logic       O,
  output logic       I1,
  output logic       I2,
  output logic [2:0] op,
  output logic       busy,
  output logic       done,
  output logic [5:0] chk_cnt,
  output logic [5:0] err_cnt
`ifdef GATE_SWEEP_TRACE_EN
  ,
  output logic       fail_valid,
  output logic [2:0] fail_op,
  output logic       fail_I1,
  output logic       fail_I2
`endif
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [5:0] CNT_MAX     = 6'd32;

  sweep_state_t state, state_d;
  logic [3:0]   settle_cnt;
  logic [2:0]   cur_op;
  logic [1:0]   cur_vec;
  logic         last, mask_zero, accept, advance, mismatch;

  assign accept   = (state == ST_IDLE) && start && !abort;
  assign advance  = (state == ST_SAMPLE) && !abort;
  assign mismatch = (O != gate_eval(op, I1, I2));

  gate_sweep_idx u_idx (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .mask_in   (op_en),
    .advance   (advance),
    .cur_op    (cur_op),
    .cur_vec   (cur_vec),
    .last      (last),
    .mask_zero (mask_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (start) state_d = mask_zero ? ST_DONE : ST_DRIVE;
      ST_DRIVE:  state_d = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = last ? ST_DONE : ST_DRIVE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      I1         <= 1'b0;
      I2         <= 1'b0;
      op         <= OP_AND;
      busy       <= 1'b0;
      done       <= 1'b0;
      chk_cnt    <= 6'd0;
      err_cnt    <= 6'd0;
      settle_cnt <= 4'd0;
`ifdef GATE_SWEEP_TRACE_EN
      fail_valid <= 1'b0;
      fail_op    <= OP_AND;
      fail_I1    <= 1'b0;
      fail_I2    <= 1'b0;
`endif
    end else if (abort) begin
      I1   <= 1'b0;
      I2   <= 1'b0;
      op   <= OP_AND;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
      case (state)
        ST_IDLE: if (start) begin
          chk_cnt <= 6'd0;
          err_cnt <= 6'd0;
          busy    <= !mask_zero;
`ifdef GATE_SWEEP_TRACE_EN
          fail_valid <= 1'b0;
          fail_op    <= OP_AND;
          fail_I1    <= 1'b0;
          fail_I2    <= 1'b0;
`endif
        end
        ST_DRIVE: begin
          op         <= cur_op;
          I1         <= cur_vec[1];
          I2         <= cur_vec[0];
          settle_cnt <= 4'd0;
        end
        ST_SETTLE: settle_cnt <= settle_cnt + 4'd1;
        ST_SAMPLE: begin
          if (chk_cnt != CNT_MAX) chk_cnt <= chk_cnt + 6'd1;
          if (mismatch && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + 6'd1;
`ifdef GATE_SWEEP_TRACE_EN
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_op    <= op;
            fail_I1    <= I1;
            fail_I2    <= I2;
          end
`endif
        end
        ST_DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - directed self-checking bench for gate_sweep_ctrl
module tb_gate_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] op_en = 8'h00;
  logic       O;
  logic       I1, I2, busy, done;
  logic [2:0] op;
  logic [5:0] chk_cnt, err_cnt;
`ifdef GATE_SWEEP_TRACE_EN
  logic       fail_valid, fail_I1, fail_I2;
  logic [2:0] fail_op;
`endif

  int errors = 0;
  int checks = 0;
  int o_mode = 0;          // 0 ideal gate, 1 stuck-at-0, 2 inverted gate
  logic [4:0] vec_log[$];
  int   cycles;
  logic busy_seen;

  always #5 clk = ~clk;

  // Independent truth table per op, indexed by {a,b}.
  function automatic logic ref_gate(input logic [2:0] f, input logic a, input logic b);
    logic [3:0] tbl;
    case (f)
      3'd0: tbl = 4'b1000;
      3'd1: tbl = 4'b1110;
      3'd2: tbl = 4'b0110;
      3'd3: tbl = 4'b0111;
      3'd4: tbl = 4'b0001;
      3'd5: tbl = 4'b1001;
      3'd6: tbl = 4'b0011;
      default: tbl = 4'b1100;
    endcase
    return tbl[{a, b}];
  endfunction

  assign O = (o_mode == 1) ? 1'b0 :
             (o_mode == 2) ? ~ref_gate(op, I1, I2) : ref_gate(op, I1, I2);

  gate_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .op_en   (op_en),
    .O       (O),
    .I1      (I1),
    .I2      (I2),
    .op      (op),
    .busy    (busy),
    .done    (done),
    .chk_cnt (chk_cnt),
    .err_cnt (err_cnt)
`ifdef GATE_SWEEP_TRACE_EN
    ,
    .fail_valid (fail_valid),
    .fail_op    (fail_op),
    .fail_I1    (fail_I1),
    .fail_I2    (fail_I2)
`endif
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_sweep(input logic [7:0] mask);
    @(negedge clk);
    vec_log.delete();
    op_en = mask;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs after the accepted-start edge; cycles = edges until done is seen.
  task automatic wait_done(input int budget, input int poke_a, input int poke_b);
    logic [5:0] prev_chk;
    prev_chk  = chk_cnt;
    cycles    = 0;
    busy_seen = 1'b0;
    while (cycles < budget) begin
      @(posedge clk);
      cycles++;
      #1;
      start = (cycles == poke_a) || (cycles == poke_b);
      if (busy) busy_seen = 1'b1;
      if (chk_cnt != prev_chk) vec_log.push_back({op, I1, I2});
      prev_chk = chk_cnt;
      if (done) break;
    end
    start = 1'b0;
    if (!done) check_eq("done_timeout", 0, 1);
  endtask

  task automatic check_order(input string tag, input logic [7:0] mask);
    logic [4:0] exp_q[$];
    int bad;
    for (int i = 0; i < 8; i++)
      if (mask[i])
        for (int v = 0; v < 4; v++) exp_q.push_back({3'(i), 2'(v)});
    bad = 0;
    check_eq({tag, "_len"}, vec_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < vec_log.size(); k++)
      if (vec_log[k] !== exp_q[k]) bad++;
    check_eq({tag, "_misordered"}, bad, 0);
  endtask

  initial begin
    rst = 1'b1;
    #12;
    check_eq("rst_I1", I1, 0);
    check_eq("rst_I2", I2, 0);
    check_eq("rst_op", op, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_chk", chk_cnt, 0);
    check_eq("rst_err", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Full sweep, ideal gate.
    o_mode = 0;
    start_sweep(8'hFF);
    wait_done(400, -1, -1);
    check_eq("full_cycles", cycles, 129);
    check_eq("full_chk", chk_cnt, 32);
    check_eq("full_err", err_cnt, 0);
    check_eq("full_busy_at_done", busy, 0);
    check_order("full_order", 8'hFF);
    @(posedge clk); #1;
    check_eq("full_done_pulse", done, 0);

    // XOR only with O stuck low.
    o_mode = 1;
    start_sweep(8'h04);
    wait_done(100, -1, -1);
    check_eq("xor_cycles", cycles, 17);
    check_eq("xor_chk", chk_cnt, 4);
    check_eq("xor_err", err_cnt, 2);
`ifdef GATE_SWEEP_TRACE_EN
    check_eq("xor_fail_valid", fail_valid, 1);
    check_eq("xor_fail_op", fail_op, 2);
    check_eq("xor_fail_I1", fail_I1, 0);
    check_eq("xor_fail_I2", fail_I2, 1);
`endif

    // Empty mask.
    o_mode = 0;
    start_sweep(8'h00);
    wait_done(10, -1, -1);
    check_eq("empty_cycles", cycles, 1);
    check_eq("empty_busy_seen", busy_seen, 0);
    check_eq("empty_chk", chk_cnt, 0);
    check_eq("empty_err", err_cnt, 0);

    // Abort during SETTLE of the second vector.
    start_sweep(8'hFF);
    repeat (5) @(posedge clk);
    #1;
    check_eq("abort_pre_I2", I2, 1);
    check_eq("abort_pre_chk", chk_cnt, 1);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_I1", I1, 0);
    check_eq("abort_I2", I2, 0);
    check_eq("abort_op", op, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_chk", chk_cnt, 1);
    @(negedge clk);
    abort = 1'b0;
    begin
      int done_hits = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (done) done_hits++;
      end
      check_eq("abort_no_done", done_hits, 0);
      check_eq("abort_chk_held", chk_cnt, 1);
    end

    // Asynchronous reset mid-sweep, then a clean rerun.
    start_sweep(8'h21);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_chk", chk_cnt, 0);
    check_eq("arst_outs", {op, I1, I2}, 0);
    @(negedge clk);
    rst = 1'b0;
    start_sweep(8'h21);
    wait_done(200, -1, -1);
    check_eq("rerun_cycles", cycles, 33);
    check_eq("rerun_chk", chk_cnt, 8);
    check_eq("rerun_err", err_cnt, 0);
    check_order("rerun_order", 8'h21);

    // Start pulses while busy, inverted gate so every vector mismatches.
    o_mode = 2;
    start_sweep(8'h12);
    wait_done(200, 7, 20);
    check_eq("rebusy_cycles", cycles, 33);
    check_eq("rebusy_chk", chk_cnt, 8);
    check_eq("rebusy_err", err_cnt, 8);
    check_order("rebusy_order", 8'h12);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rebusy_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
